// File: rtl/dvi_pattern_sequencer.sv
//-----------------------------------------------------------------------------
// dvi_pattern_sequencer
//
// Run controller for the RGB timing generator in the DVI tester. It starts
// and stops the generator through its enable/stopped handshake, counts
// frames on the falling edge of vsync, and steps the test-pattern selector
// at frame boundaries. Stepping is automatic after a fixed number of frames,
// or manual on request.
//
// Parameters:
//   NUM_PATTERNS       - number of patterns, patternSel wraps to 0 (2..8)
//   FRAMES_PER_PATTERN - frames per pattern when auto-advance is on (>=1)
//   START_TIMEOUT      - cycles allowed for genStopped to fall after enable
//   AUTO_ADVANCE       - 1 = step automatically, 0 = manual stepping only
//
// Ports:
//   pixelClk    in   pixel clock, the only clock
//   reset       in   synchronous active-high reset
//   start       in   pulse: begin output
//   stopReq     in   pulse: stop after the current frame
//   nextPattern in   pulse: step pattern (next frame boundary, or at once
//                    while idle)
//   genStopped  in   generator idle flag (1 = idle)
//   genVs       in   generator vsync, active low, idles high
//   genEnable   out  enable to the timing generator
//   patternSel  out  selected pattern, 0..NUM_PATTERNS-1
//   frameCount  out  frames since start, wraps 0xFFFF -> 0
//   running     out  high in RUN only
//   fault       out  sticky start-timeout flag
//-----------------------------------------------------------------------------
module dvi_pattern_sequencer #(
  parameter int NUM_PATTERNS       = 8,
  parameter int FRAMES_PER_PATTERN = 60,
  parameter int START_TIMEOUT      = 16,
  parameter int AUTO_ADVANCE       = 1
) (
  input  logic        pixelClk,
  input  logic        reset,
  input  logic        start,
  input  logic        stopReq,
  input  logic        nextPattern,
  input  logic        genStopped,
  input  logic        genVs,
  output logic        genEnable,
  output logic [2:0]  patternSel,
  output logic [15:0] frameCount,
  output logic        running,
  output logic        fault
);

  localparam int TIMER_W = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(START_TIMEOUT - 1);
  localparam logic [2:0]         LAST_PAT   = 3'(NUM_PATTERNS - 1);
  localparam logic [15:0]        LAST_FRAME = 16'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_FAULT
  } state_t;

  state_t              state_q, state_d;
  logic                gen_enable_q, gen_enable_d;
  logic [2:0]          pattern_sel_q, pattern_sel_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                fault_q, fault_d;
  logic                vs_last_q, vs_last_d;
  logic                pending_next_q, pending_next_d;
  logic [15:0]         frame_ctr_q, frame_ctr_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;

  logic                frame_edge;
  logic                auto_hit;
  logic [2:0]          pattern_inc;

  // vsync is active low, so a frame boundary is a high-to-low transition
  // seen against the previous cycle's sample.
  assign frame_edge = vs_last_q & ~genVs;

  // Auto-advance fires on the edge that closes the last frame of a pattern.
  assign auto_hit = (AUTO_ADVANCE != 0) && (frame_ctr_q == LAST_FRAME);

  // Wrapping increment of the pattern selector, shared by IDLE preview
  // stepping and RUN frame-boundary stepping.
  assign pattern_inc = (pattern_sel_q == LAST_PAT) ? 3'd0 : pattern_sel_q + 3'd1;

  // Next-state and next-output logic. Every register holds by default, and
  // each state only touches what it owns.
  always_comb begin
    state_d        = state_q;
    gen_enable_d   = gen_enable_q;
    pattern_sel_d  = pattern_sel_q;
    frame_count_d  = frame_count_q;
    fault_d        = fault_q;
    vs_last_d      = genVs;
    pending_next_d = pending_next_q;
    frame_ctr_d    = frame_ctr_q;
    timer_d        = timer_q;

    unique case (state_q)
      S_IDLE: begin
        gen_enable_d = 1'b0;
        // Stepping while stopped gives an immediate preview on the monitor.
        if (nextPattern) begin
          pattern_sel_d = pattern_inc;
        end
        // A stop request in the same cycle cancels the start.
        if (start && !stopReq) begin
          gen_enable_d = 1'b1;
          timer_d      = '0;
          state_d      = S_ARM;
        end
      end

      S_ARM: begin
        gen_enable_d = 1'b1;
        if (stopReq) begin
          gen_enable_d = 1'b0;
          state_d      = S_DRAIN;
        end else if (!genStopped) begin
          // The generator has acknowledged, so begin counting from a clean
          // frame and pattern dwell.
          frame_count_d  = '0;
          frame_ctr_d    = '0;
          pending_next_d = 1'b0;
          state_d        = S_RUN;
        end else if (timer_q == TIMER_LAST) begin
          gen_enable_d = 1'b0;
          fault_d      = 1'b1;
          state_d      = S_FAULT;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_RUN: begin
        gen_enable_d = 1'b1;
        // A manual request and an auto-advance on the same edge still step
        // the pattern only once.
        if (frame_edge) begin
          frame_count_d = frame_count_q + 16'd1;
          if (pending_next_q || auto_hit) begin
            pattern_sel_d  = pattern_inc;
            frame_ctr_d    = '0;
            pending_next_d = 1'b0;
          end else begin
            frame_ctr_d = frame_ctr_q + 16'd1;
          end
        end
        // A request arriving on the edge itself waits for the next edge.
        if (nextPattern) begin
          pending_next_d = 1'b1;
        end
        // The frame edge of this cycle is still counted above before we
        // leave; a queued step is dropped.
        if (stopReq) begin
          gen_enable_d   = 1'b0;
          pending_next_d = 1'b0;
          state_d        = S_DRAIN;
        end
      end

      S_DRAIN: begin
        // The generator finishes its current frame on its own; there is no
        // timeout here and frame edges are ignored.
        gen_enable_d = 1'b0;
        if (genStopped) begin
          state_d = S_IDLE;
        end
      end

      S_FAULT: begin
        // Parked until the operator acknowledges with a stop; the fault
        // flag remains set until reset.
        gen_enable_d = 1'b0;
        fault_d      = 1'b1;
        if (stopReq) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        gen_enable_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset. vsync idles high,
  // so the last sample resets to 1 to avoid a false edge after reset.
  always_ff @(posedge pixelClk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      gen_enable_q   <= 1'b0;
      pattern_sel_q  <= 3'd0;
      frame_count_q  <= 16'd0;
      fault_q        <= 1'b0;
      vs_last_q      <= 1'b1;
      pending_next_q <= 1'b0;
      frame_ctr_q    <= 16'd0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      gen_enable_q   <= gen_enable_d;
      pattern_sel_q  <= pattern_sel_d;
      frame_count_q  <= frame_count_d;
      fault_q        <= fault_d;
      vs_last_q      <= vs_last_d;
      pending_next_q <= pending_next_d;
      frame_ctr_q    <= frame_ctr_d;
      timer_q        <= timer_d;
    end
  end

  assign genEnable  = gen_enable_q;
  assign patternSel = pattern_sel_q;
  assign frameCount = frame_count_q;
  assign running    = (state_q == S_RUN);
  assign fault      = fault_q;

endmodule

// File: tb/tb_dvi_pattern_sequencer.sv
//-----------------------------------------------------------------------------
// Testbench for dvi_pattern_sequencer. Two instances share every input:
// dutA steps automatically (3 patterns, 2 frames each) and dutB steps
// manually only (8 patterns). Each check looks at whichever instance the
// behaviour applies to.
//-----------------------------------------------------------------------------
module tb_dvi_pattern_sequencer;

  logic        pixelClk;
  logic        reset;
  logic        start;
  logic        stopReq;
  logic        nextPattern;
  logic        genStopped;
  logic        genVs;

  logic        genEnableA, runningA, faultA;
  logic [2:0]  patternSelA;
  logic [15:0] frameCountA;
  logic        genEnableB, runningB, faultB;
  logic [2:0]  patternSelB;
  logic [15:0] frameCountB;

  int compared;
  int mismatched;

  typedef struct {
    logic [2:0]  expPat;
    logic [15:0] expCount;
  } frameVec_t;

  typedef struct {
    logic [2:0] expPatA;
    logic [2:0] expPatB;
  } previewVec_t;

  frameVec_t   frameVecs[7];
  previewVec_t previewVecs[8];

  dvi_pattern_sequencer #(
    .NUM_PATTERNS(3), .FRAMES_PER_PATTERN(2), .START_TIMEOUT(16), .AUTO_ADVANCE(1)
  ) dutA (
    .pixelClk(pixelClk), .reset(reset), .start(start), .stopReq(stopReq),
    .nextPattern(nextPattern), .genStopped(genStopped), .genVs(genVs),
    .genEnable(genEnableA), .patternSel(patternSelA), .frameCount(frameCountA),
    .running(runningA), .fault(faultA)
  );

  dvi_pattern_sequencer #(
    .NUM_PATTERNS(8), .FRAMES_PER_PATTERN(60), .START_TIMEOUT(16), .AUTO_ADVANCE(0)
  ) dutB (
    .pixelClk(pixelClk), .reset(reset), .start(start), .stopReq(stopReq),
    .nextPattern(nextPattern), .genStopped(genStopped), .genVs(genVs),
    .genEnable(genEnableB), .patternSel(patternSelB), .frameCount(frameCountB),
    .running(runningB), .fault(faultB)
  );

  initial pixelClk = 1'b0;
  always #5 pixelClk = ~pixelClk;

  // Advance a number of clocks and settle 1 time unit past the edge, so
  // outputs are sampled and inputs are changed away from the active edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge pixelClk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    applyStimulus(1);
    start = 1'b0;
  endtask

  task automatic pulseStop();
    stopReq = 1'b1;
    applyStimulus(1);
    stopReq = 1'b0;
  endtask

  task automatic pulseNext();
    nextPattern = 1'b1;
    applyStimulus(1);
    nextPattern = 1'b0;
  endtask

  // One vsync low pulse; the fall is seen on the first clock.
  task automatic vsFall();
    genVs = 1'b0;
    applyStimulus(1);
    genVs = 1'b1;
    applyStimulus(1);
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(2);
    reset = 1'b0;
    genStopped = 1'b1;
    genVs = 1'b1;
  endtask

  // start, then the generator acknowledges 3 cycles later.
  task automatic startRun();
    pulseStart();
    checkOutput("start_genEnable", {15'd0, genEnableA}, 16'd1);
    applyStimulus(2);
    checkOutput("arm_notRunning", {15'd0, runningA}, 16'd0);
    genStopped = 1'b0;
    applyStimulus(1);
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b1;
    start       = 1'b0;
    stopReq     = 1'b0;
    nextPattern = 1'b0;
    genStopped  = 1'b1;
    genVs       = 1'b1;

    // Expected patternSel/frameCount of dutA after each of 7 frame edges.
    frameVecs[0] = '{3'd0, 16'd1};
    frameVecs[1] = '{3'd1, 16'd2};
    frameVecs[2] = '{3'd1, 16'd3};
    frameVecs[3] = '{3'd2, 16'd4};
    frameVecs[4] = '{3'd2, 16'd5};
    frameVecs[5] = '{3'd0, 16'd6};
    frameVecs[6] = '{3'd0, 16'd7};

    // Expected patternSel after each nextPattern pulse while idle.
    previewVecs[0] = '{3'd1, 3'd1};
    previewVecs[1] = '{3'd2, 3'd2};
    previewVecs[2] = '{3'd0, 3'd3};
    previewVecs[3] = '{3'd1, 3'd4};
    previewVecs[4] = '{3'd2, 3'd5};
    previewVecs[5] = '{3'd0, 3'd6};
    previewVecs[6] = '{3'd1, 3'd7};
    previewVecs[7] = '{3'd2, 3'd0};

    doReset();
    $display("[TB] reset values");
    checkOutput("rst_genEnable", {15'd0, genEnableA}, 16'd0);
    checkOutput("rst_patternSel", {13'd0, patternSelA}, 16'd0);
    checkOutput("rst_frameCount", frameCountA, 16'd0);
    checkOutput("rst_running", {15'd0, runningA}, 16'd0);
    checkOutput("rst_fault", {15'd0, faultA}, 16'd0);

    $display("[TB] idle preview stepping");
    for (int i = 0; i < 8; i++) begin
      pulseNext();
      checkOutput($sformatf("preview_A_%0d", i), {13'd0, patternSelA},
                  {13'd0, previewVecs[i].expPatA});
      checkOutput($sformatf("preview_B_%0d", i), {13'd0, patternSelB},
                  {13'd0, previewVecs[i].expPatB});
    end

    $display("[TB] start handshake and auto-advance");
    doReset();
    startRun();
    checkOutput("run_running", {15'd0, runningA}, 16'd1);
    checkOutput("run_frameCount", frameCountA, 16'd0);
    checkOutput("run_patternSel", {13'd0, patternSelA}, 16'd0);
    for (int i = 0; i < 7; i++) begin
      vsFall();
      checkOutput($sformatf("auto_pat_%0d", i), {13'd0, patternSelA},
                  {13'd0, frameVecs[i].expPat});
      checkOutput($sformatf("auto_cnt_%0d", i), frameCountA, frameVecs[i].expCount);
    end
    checkOutput("manual_noAuto_pat", {13'd0, patternSelB}, 16'd0);
    checkOutput("manual_cnt", frameCountB, 16'd7);

    $display("[TB] manual step is deferred to the frame boundary");
    doReset();
    startRun();
    applyStimulus(3);
    for (int i = 0; i < 3; i++) begin
      pulseNext();
      applyStimulus(2);
    end
    checkOutput("manual_hold", {13'd0, patternSelB}, 16'd0);
    vsFall();
    checkOutput("manual_step", {13'd0, patternSelB}, 16'd1);
    vsFall();
    checkOutput("manual_once", {13'd0, patternSelB}, 16'd1);
    checkOutput("manual_cnt2", frameCountB, 16'd2);

    $display("[TB] stop on a frame edge, then drain");
    genVs   = 1'b0;
    stopReq = 1'b1;
    applyStimulus(1);
    genVs   = 1'b1;
    stopReq = 1'b0;
    checkOutput("stop_edge_cnt", frameCountB, 16'd3);
    checkOutput("stop_genEnable", {15'd0, genEnableB}, 16'd0);
    checkOutput("stop_running", {15'd0, runningB}, 16'd0);
    applyStimulus(50);
    pulseStart();
    applyStimulus(49);
    checkOutput("drain_ignores_start", {15'd0, genEnableB}, 16'd0);
    vsFall();
    checkOutput("drain_ignores_edge", frameCountB, 16'd3);
    genStopped = 1'b1;
    applyStimulus(2);
    pulseStart();
    checkOutput("idle_after_drain", {15'd0, genEnableB}, 16'd1);

    $display("[TB] start timeout");
    doReset();
    pulseStart();
    applyStimulus(15);
    checkOutput("timeout_before_fault", {15'd0, faultA}, 16'd0);
    checkOutput("timeout_before_en", {15'd0, genEnableA}, 16'd1);
    applyStimulus(1);
    checkOutput("timeout_fault", {15'd0, faultA}, 16'd1);
    checkOutput("timeout_genEnable", {15'd0, genEnableA}, 16'd0);
    pulseStart();
    applyStimulus(1);
    checkOutput("fault_ignores_start", {15'd0, genEnableA}, 16'd0);
    pulseStop();
    checkOutput("fault_sticky", {15'd0, faultA}, 16'd1);
    pulseStart();
    checkOutput("fault_idle_start", {15'd0, genEnableA}, 16'd1);
    checkOutput("fault_still_sticky", {15'd0, faultA}, 16'd1);

    $display("[TB] reset mid-run");
    doReset();
    startRun();
    for (int i = 0; i < 5; i++) vsFall();
    checkOutput("pre_rst_pat", {13'd0, patternSelA}, 16'd2);
    checkOutput("pre_rst_cnt", frameCountA, 16'd5);
    reset = 1'b1;
    applyStimulus(1);
    checkOutput("midrst_genEnable", {15'd0, genEnableA}, 16'd0);
    checkOutput("midrst_patternSel", {13'd0, patternSelA}, 16'd0);
    checkOutput("midrst_frameCount", frameCountA, 16'd0);
    checkOutput("midrst_running", {15'd0, runningA}, 16'd0);
    checkOutput("midrst_fault", {15'd0, faultA}, 16'd0);
    reset = 1'b0;
    genVs = 1'b0;
    applyStimulus(2);
    genVs = 1'b1;
    applyStimulus(1);
    checkOutput("postrst_no_count", frameCountA, 16'd0);
    checkOutput("postrst_idle", {15'd0, runningA}, 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
